// File: rtl/axis_collision_check_if.sv
// Handshake/bus bundle for axis_collision_check: three per-axis float inputs, threshold and result.
// Adds out_nan when AXIS_COLLISION_NAN_CHECK_EN is defined.
interface axis_collision_check_if;
  logic [31:0] in_x;
  logic [31:0] in_y;
  logic [31:0] in_z;
  logic        in_x_stb;
  logic        in_y_stb;
  logic        in_z_stb;
  logic        in_x_ack;
  logic        in_y_ack;
  logic        in_z_ack;
  logic [31:0] threshold;
  logic        out_hit;
  logic [31:0] out_dist;
  logic        out_stb;
  logic        out_ack;
  logic [15:0] hit_count;
`ifdef AXIS_COLLISION_NAN_CHECK_EN
  logic        out_nan;
`endif

  modport slave (
    input  in_x, in_y, in_z, in_x_stb, in_y_stb, in_z_stb, threshold, out_ack,
    output in_x_ack, in_y_ack, in_z_ack, out_hit, out_dist, out_stb, hit_count
`ifdef AXIS_COLLISION_NAN_CHECK_EN
    , output out_nan
`endif
  );

  modport master (
    output in_x, in_y, in_z, in_x_stb, in_y_stb, in_z_stb, threshold, out_ack,
    input  in_x_ack, in_y_ack, in_z_ack, out_hit, out_dist, out_stb, hit_count
`ifdef AXIS_COLLISION_NAN_CHECK_EN
    , input out_nan
`endif
  );
endinterface

// File: rtl/axis_collision_check.sv
// Collects three float axis differences, reports Chebyshev distance and per-axis threshold hit.
// Optional NaN detection controlled by macro AXIS_COLLISION_NAN_CHECK_EN.
module axis_collision_check (
  input logic              clk,
  input logic              rst,
  axis_collision_check_if.slave bus
);

  typedef enum logic [1:0] {S_COLLECT, S_EVAL, S_OUTPUT} state_t;

  state_t      r_state;
  state_t      w_stateNext;
  logic [2:0]  r_ack;
  logic [2:0]  r_cap;
  logic [2:0]  w_ackNext;
  logic [2:0]  w_capNext;
  logic [2:0]  w_stb;
  logic [2:0]  w_xfer;
  logic [2:0]  w_capAfter;
  logic        w_release;
  logic [31:0] r_x;
  logic [31:0] r_y;
  logic [31:0] r_z;
  logic [31:0] r_dist;
  logic        r_hit;
  logic        r_stb;
  logic [15:0] r_hitCount;
  logic [30:0] w_magX;
  logic [30:0] w_magY;
  logic [30:0] w_magZ;
  logic [30:0] w_thr;
  logic [30:0] w_maxXY;
  logic [30:0] w_max;
  logic        w_hitNext;
  logic        w_unusedSigns;

  // Bit order everywhere is {z, y, x}
  assign w_stb      = {bus.in_z_stb, bus.in_y_stb, bus.in_x_stb};
  assign w_xfer     = r_ack & w_stb;
  assign w_capAfter = r_cap | w_xfer;
  assign w_release  = (r_state == S_OUTPUT) && r_stb && bus.out_ack;

  always_comb begin
    w_stateNext = r_state;
    w_ackNext   = 3'b000;
    w_capNext   = r_cap;
    case (r_state)
      S_COLLECT: begin
        w_capNext = w_capAfter;
        if (&w_capAfter) begin
          w_stateNext = S_EVAL;
        end else begin
          w_ackNext = ~w_capAfter;
        end
      end
      S_EVAL: begin
        w_stateNext = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (w_release) begin
          w_stateNext = S_COLLECT;
          w_capNext   = 3'b000;
          w_ackNext   = 3'b111;
        end
      end
      default: begin
        w_stateNext = S_COLLECT;
        w_capNext   = 3'b000;
      end
    endcase
  end

  // Acks are registered so they stay low during reset and rise on the first edge after it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_COLLECT;
      r_ack   <= 3'b000;
      r_cap   <= 3'b000;
    end else begin
      r_state <= w_stateNext;
      r_ack   <= w_ackNext;
      r_cap   <= w_capNext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x <= 32'h0;
      r_y <= 32'h0;
      r_z <= 32'h0;
    end else begin
      if (w_xfer[0]) r_x <= bus.in_x;
      if (w_xfer[1]) r_y <= bus.in_y;
      if (w_xfer[2]) r_z <= bus.in_z;
    end
  end

  // Magnitudes compare as unsigned integers once the sign bit is dropped
  assign w_magX  = r_x[30:0];
  assign w_magY  = r_y[30:0];
  assign w_magZ  = r_z[30:0];
  assign w_thr   = bus.threshold[30:0];
  assign w_maxXY = (w_magX >= w_magY) ? w_magX : w_magY;
  assign w_max   = (w_maxXY >= w_magZ) ? w_maxXY : w_magZ;
  assign w_unusedSigns = ^{bus.threshold[31], r_x[31], r_y[31], r_z[31]};

`ifdef AXIS_COLLISION_NAN_CHECK_EN
  logic w_nanNext;
  logic r_nan;

  function automatic logic isNan(input logic [31:0] v);
    return (&v[30:23]) && (|v[22:0]);
  endfunction

  assign w_nanNext = isNan(r_x) || isNan(r_y) || isNan(r_z);
  assign w_hitNext = (w_magX <= w_thr) && (w_magY <= w_thr) && (w_magZ <= w_thr) && !w_nanNext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nan <= 1'b0;
    end else if (r_state == S_EVAL) begin
      r_nan <= w_nanNext;
    end
  end

  assign bus.out_nan = r_nan;
`else
  assign w_hitNext = (w_magX <= w_thr) && (w_magY <= w_thr) && (w_magZ <= w_thr);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dist     <= 32'h0;
      r_hit      <= 1'b0;
      r_stb      <= 1'b0;
      r_hitCount <= 16'h0;
    end else if (r_state == S_EVAL) begin
      r_dist <= {1'b0, w_max};
      r_hit  <= w_hitNext;
      r_stb  <= 1'b1;
    end else if (w_release) begin
      r_stb <= 1'b0;
      if (r_hit && (r_hitCount != 16'hFFFF)) begin
        r_hitCount <= r_hitCount + 16'd1;
      end
    end
  end

  assign bus.in_x_ack  = r_ack[0];
  assign bus.in_y_ack  = r_ack[1];
  assign bus.in_z_ack  = r_ack[2];
  assign bus.out_hit   = r_hit;
  assign bus.out_dist  = r_dist;
  assign bus.out_stb   = r_stb;
  assign bus.hit_count = r_hitCount;

endmodule

// File: tb/tb_axis_collision_check.sv
// Directed bench for axis_collision_check: handshake timing, compare results, stall, reset, saturation.
// Exercises out_nan when AXIS_COLLISION_NAN_CHECK_EN is defined.
module tb_axis_collision_check;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  axis_collision_check_if bus ();

  axis_collision_check dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle so outputs are sampled away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] acks();
    return {bus.in_z_ack, bus.in_y_ack, bus.in_x_ack};
  endfunction

  task automatic deliver(input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] z, input logic [31:0] thr);
    bus.in_x = x;
    bus.in_y = y;
    bus.in_z = z;
    bus.threshold = thr;
    bus.in_x_stb = 1'b1;
    bus.in_y_stb = 1'b1;
    bus.in_z_stb = 1'b1;
    tick();
    bus.in_x_stb = 1'b0;
    bus.in_y_stb = 1'b0;
    bus.in_z_stb = 1'b0;
    tick();
  endtask

  task automatic ackResult();
    bus.out_ack = 1'b1;
    tick();
    bus.out_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (acks() !== 3'b000) begin failures++; $display("[TB] FAIL reset_acks got=%b want=000", acks()); end
    checks++;
    if (bus.out_stb !== 1'b0 || bus.out_hit !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_stb_hit got=%b%b want=00", bus.out_stb, bus.out_hit);
    end
    checks++;
    if (bus.out_dist !== 32'h0 || bus.hit_count !== 16'h0) begin
      failures++; $display("[TB] FAIL reset_dist_count got=%h/%h want=0/0", bus.out_dist, bus.hit_count);
    end
`ifdef AXIS_COLLISION_NAN_CHECK_EN
    checks++;
    if (bus.out_nan !== 1'b0) begin failures++; $display("[TB] FAIL reset_nan got=%b want=0", bus.out_nan); end
`endif
    rst = 1'b0;
    checks++;
    if (acks() !== 3'b000) begin failures++; $display("[TB] FAIL acks_before_edge got=%b want=000", acks()); end
    tick();
    checks++;
    if (acks() !== 3'b111) begin failures++; $display("[TB] FAIL acks_first_edge got=%b want=111", acks()); end
  endtask

  task automatic test_together();
    bus.in_x = 32'h3F800000;
    bus.in_y = 32'hBF000000;
    bus.in_z = 32'h00000000;
    bus.threshold = 32'h40000000;
    bus.in_x_stb = 1'b1;
    bus.in_y_stb = 1'b1;
    bus.in_z_stb = 1'b1;
    tick();
    bus.in_x_stb = 1'b0;
    bus.in_y_stb = 1'b0;
    bus.in_z_stb = 1'b0;
    checks++;
    if (acks() !== 3'b000 || bus.out_stb !== 1'b0) begin
      failures++; $display("[TB] FAIL together_eval got acks=%b stb=%b want 000/0", acks(), bus.out_stb);
    end
    tick();
    checks++;
    if (bus.out_stb !== 1'b1 || bus.out_hit !== 1'b1 || bus.out_dist !== 32'h3F800000) begin
      failures++; $display("[TB] FAIL together_result got stb=%b hit=%b dist=%h want 1/1/3f800000",
                           bus.out_stb, bus.out_hit, bus.out_dist);
    end
    ackResult();
    checks++;
    if (bus.out_stb !== 1'b0 || bus.hit_count !== 16'd1 || acks() !== 3'b111) begin
      failures++; $display("[TB] FAIL together_ack got stb=%b cnt=%h acks=%b want 0/0001/111",
                           bus.out_stb, bus.hit_count, acks());
    end
  endtask

  task automatic test_staggered();
    logic [2:0] expAck;
    logic       expStb;
    bus.in_x = 32'h3F800000;
    bus.in_y = 32'hC0400000;
    bus.in_z = 32'h3F000000;
    bus.threshold = 32'h40000000;
    for (int c = 0; c < 9; c++) begin
      bus.in_x_stb = (c == 0) || (c == 5);
      if (c == 5) bus.in_x = 32'h7F000000;
      bus.in_z_stb = (c == 3);
      bus.in_y_stb = (c == 7);
      tick();
      expAck = (c + 1 >= 8) ? 3'b000 : {(c + 1 < 4), 1'b1, 1'b0};
      expStb = (c + 1 >= 9);
      checks++;
      if (acks() !== expAck || bus.out_stb !== expStb) begin
        failures++; $display("[TB] FAIL staggered_cycle%0d got acks=%b stb=%b want %b/%b",
                             c + 1, acks(), bus.out_stb, expAck, expStb);
      end
    end
    bus.in_x_stb = 1'b0;
    bus.in_y_stb = 1'b0;
    bus.in_z_stb = 1'b0;
    checks++;
    if (bus.out_hit !== 1'b0 || bus.out_dist !== 32'h40400000) begin
      failures++; $display("[TB] FAIL staggered_result got hit=%b dist=%h want 0/40400000", bus.out_hit, bus.out_dist);
    end
    ackResult();
    checks++;
    if (bus.hit_count !== 16'd1) begin failures++; $display("[TB] FAIL staggered_count got=%h want=0001", bus.hit_count); end
  endtask

  task automatic test_stall();
    bus.out_ack = 1'b1;
    tick();
    bus.out_ack = 1'b0;
    checks++;
    if (bus.hit_count !== 16'd1 || acks() !== 3'b111 || bus.out_stb !== 1'b0) begin
      failures++; $display("[TB] FAIL idle_ack_ignored got cnt=%h acks=%b stb=%b want 0001/111/0",
                           bus.hit_count, acks(), bus.out_stb);
    end
    deliver(32'h40000000, 32'h80000000, 32'hC0000000, 32'h40000000);
    checks++;
    if (bus.out_stb !== 1'b1 || bus.out_hit !== 1'b1 || bus.out_dist !== 32'h40000000) begin
      failures++; $display("[TB] FAIL equal_threshold got stb=%b hit=%b dist=%h want 1/1/40000000",
                           bus.out_stb, bus.out_hit, bus.out_dist);
    end
    for (int k = 0; k < 10; k++) begin
      bus.in_x_stb = k[0];
      bus.in_y_stb = k[0];
      bus.in_z_stb = k[0];
      bus.in_x = 32'h7F7FFFFF;
      tick();
      checks++;
      if (bus.out_stb !== 1'b1 || bus.out_hit !== 1'b1 || bus.out_dist !== 32'h40000000 || acks() !== 3'b000) begin
        failures++; $display("[TB] FAIL stall_hold%0d got stb=%b hit=%b dist=%h acks=%b want 1/1/40000000/000",
                             k, bus.out_stb, bus.out_hit, bus.out_dist, acks());
      end
    end
    bus.in_x_stb = 1'b0;
    bus.in_y_stb = 1'b0;
    bus.in_z_stb = 1'b0;
    ackResult();
    checks++;
    if (bus.out_stb !== 1'b0 || bus.hit_count !== 16'd2 || acks() !== 3'b111) begin
      failures++; $display("[TB] FAIL stall_release got stb=%b cnt=%h acks=%b want 0/0002/111",
                           bus.out_stb, bus.hit_count, acks());
    end
  endtask

  task automatic test_reset_mid();
    bus.in_x = 32'h7F000000;
    bus.in_y = 32'h7F000000;
    bus.in_x_stb = 1'b1;
    bus.in_y_stb = 1'b1;
    tick();
    bus.in_x_stb = 1'b0;
    bus.in_y_stb = 1'b0;
    checks++;
    if (acks() !== 3'b100) begin failures++; $display("[TB] FAIL partial_capture got=%b want=100", acks()); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (acks() !== 3'b000 || bus.out_stb !== 1'b0 || bus.hit_count !== 16'h0 || bus.out_dist !== 32'h0) begin
      failures++; $display("[TB] FAIL mid_reset got acks=%b stb=%b cnt=%h dist=%h want 000/0/0000/0",
                           acks(), bus.out_stb, bus.hit_count, bus.out_dist);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (acks() !== 3'b111) begin failures++; $display("[TB] FAIL post_reset_acks got=%b want=111", acks()); end
    bus.in_z = 32'hBF400000;
    bus.in_z_stb = 1'b1;
    tick();
    bus.in_z_stb = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.out_stb !== 1'b0 || acks() !== 3'b011) begin
      failures++; $display("[TB] FAIL discard_partial got stb=%b acks=%b want 0/011", bus.out_stb, acks());
    end
    bus.in_x = 32'h3F000000;
    bus.in_y = 32'h3E800000;
    bus.threshold = 32'h3F800000;
    bus.in_x_stb = 1'b1;
    bus.in_y_stb = 1'b1;
    tick();
    bus.in_x_stb = 1'b0;
    bus.in_y_stb = 1'b0;
    tick();
    checks++;
    if (bus.out_stb !== 1'b1 || bus.out_hit !== 1'b1 || bus.out_dist !== 32'h3F400000) begin
      failures++; $display("[TB] FAIL fresh_triple got stb=%b hit=%b dist=%h want 1/1/3f400000",
                           bus.out_stb, bus.out_hit, bus.out_dist);
    end
    ackResult();
    checks++;
    if (bus.hit_count !== 16'd1) begin failures++; $display("[TB] FAIL fresh_count got=%h want=0001", bus.hit_count); end
  endtask

  task automatic test_nan();
    deliver(32'h7FC00000, 32'h00000000, 32'h00000000, 32'h40000000);
`ifdef AXIS_COLLISION_NAN_CHECK_EN
    checks++;
    if (bus.out_stb !== 1'b1 || bus.out_nan !== 1'b1 || bus.out_hit !== 1'b0) begin
      failures++; $display("[TB] FAIL nan_flag got stb=%b nan=%b hit=%b want 1/1/0",
                           bus.out_stb, bus.out_nan, bus.out_hit);
    end
`else
    checks++;
    if (bus.out_stb !== 1'b1 || bus.out_hit !== 1'b0 || bus.out_dist !== 32'h7FC00000) begin
      failures++; $display("[TB] FAIL nan_as_bits got stb=%b hit=%b dist=%h want 1/0/7fc00000",
                           bus.out_stb, bus.out_hit, bus.out_dist);
    end
`endif
    ackResult();
    checks++;
    if (bus.hit_count !== 16'd1) begin failures++; $display("[TB] FAIL nan_count got=%h want=0001", bus.hit_count); end
  endtask

  task automatic test_saturate();
    force dut.r_hitCount = 16'hFFFE;
    tick();
    release dut.r_hitCount;
    tick();
    checks++;
    if (bus.hit_count !== 16'hFFFE) begin failures++; $display("[TB] FAIL preload got=%h want=fffe", bus.hit_count); end
    for (int k = 0; k < 3; k++) begin
      deliver(32'h00000000, 32'h80000000, 32'h3F800000, 32'h40000000);
      checks++;
      if (bus.out_hit !== 1'b1 || bus.out_dist !== 32'h3F800000) begin
        failures++; $display("[TB] FAIL sat_hit%0d got hit=%b dist=%h want 1/3f800000", k, bus.out_hit, bus.out_dist);
      end
      ackResult();
      checks++;
      if (bus.hit_count !== 16'hFFFF) begin
        failures++; $display("[TB] FAIL sat_count%0d got=%h want=ffff", k, bus.hit_count);
      end
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    bus.in_x     = 32'h0;
    bus.in_y     = 32'h0;
    bus.in_z     = 32'h0;
    bus.in_x_stb = 1'b0;
    bus.in_y_stb = 1'b0;
    bus.in_z_stb = 1'b0;
    bus.threshold = 32'h0;
    bus.out_ack  = 1'b0;
    test_reset();
    test_together();
    test_staggered();
    test_stall();
    test_reset_mid();
    test_nan();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_collision_check.md
AXIS_COLLISION_CHECK -- requirements
Module: axis_collision_check

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 in_x, in_y, in_z  input  32 each  IEEE-754 single axis differences (a minus b) from the upstream adder stage.
REQ-005 in_x_stb, in_y_stb, in_z_stb  input  1 each  per-axis valid; may arrive on independent cycles.
REQ-006 in_x_ack, in_y_ack, in_z_ack  output  1 each  per-axis ready; a transfer occurs on a clk edge where stb and ack are both high.
REQ-007 threshold  input  32  IEEE-754 single per-axis limit; sign bit ignored; sampled in EVAL.
REQ-008 out_hit  output  1  1 when every axis magnitude is less than or equal to the threshold magnitude.
REQ-009 out_dist  output  32  largest of the three axis magnitudes, sign bit forced to 0 (Chebyshev distance).
REQ-010 out_stb / out_ack  output / input  1 / 1  result valid and downstream accept.
REQ-011 hit_count  output  16  saturating count of results delivered with out_hit=1.

Function
REQ-012 The block SHALL implement FSM states COLLECT, EVAL and OUTPUT.
REQ-013 In COLLECT, each axis ack SHALL be high only while that axis is not yet captured. On transfer, the block SHALL latch the data, set that axis's captured flag, and drop that ack on the next cycle.
REQ-014 Simultaneous stb on any subset of axes SHALL capture all of them on the same edge.
REQ-015 COLLECT SHALL go to EVAL on the edge after which all three captured flags are set. Axes captured early SHALL hold their value and ignore further stb.
REQ-016 Magnitude comparison SHALL be an unsigned compare of bits [30:0]. -0 and +0 are equal. No floating-point arithmetic is performed.
REQ-017 EVAL SHALL last one cycle, register out_dist and out_hit, and go to OUTPUT. out_stb SHALL go high exactly 2 cycles after the edge that completed capture.
REQ-018 In OUTPUT, out_stb, out_hit and out_dist SHALL remain stable until out_ack is high on an edge.
REQ-019 On that out_ack edge, out_stb SHALL drop, all captured flags SHALL clear, the FSM SHALL return to COLLECT, and hit_count SHALL increment if out_hit=1.
REQ-020 hit_count SHALL saturate at 0xFFFF with no wrap.
REQ-021 All in_*_ack SHALL be low in EVAL and OUTPUT.
REQ-022 out_ack while out_stb is low SHALL be ignored.

Reset
REQ-023 On rst, the FSM SHALL go to COLLECT and clear all captured flags.
REQ-024 On rst, all in_*_ack, out_stb and out_hit SHALL be 0, and out_dist and hit_count SHALL be 0x0.
REQ-025 Reset mid-operation SHALL discard partially captured axes and any pending result without incrementing hit_count.
REQ-026 The first acks SHALL rise on the first clk edge after rst deasserts.

Configuration
REQ-027 Macro AXIS_COLLISION_NAN_CHECK_EN SHALL control NaN detection.
- Defined: adds output out_nan (1 bit, reset 0, valid with out_stb). Any captured input with exponent 0xFF and nonzero mantissa forces out_nan=1 and out_hit=0, and hit_count does not increment.
- Undefined: no out_nan port; NaN inputs are compared as plain bit patterns per REQ-016.

Verification
REQ-028 x=0x3F800000 (1.0), y=0xBF000000 (-0.5), z=0x00000000 together, threshold=0x40000000 (2.0) -> out_stb 2 cycles later, out_hit=1, out_dist=0x3F800000, hit_count=1 after ack.
REQ-029 x at cycle 0, z at cycle 3, y at cycle 7, values 1.0, -3.0 (0xC0400000), 0.5, threshold 2.0 -> each ack drops after its transfer, out_stb at cycle 9, out_hit=0, out_dist=0x40400000, hit_count unchanged.
REQ-030 Hold out_ack low 10 cycles in OUTPUT while toggling all in_*_stb -> outputs stable, no acks, no new capture; ack -> COLLECT.
REQ-031 Capture x and y, assert rst before z -> all outputs reset values; next full triple evaluates only new data.
REQ-032 Preload 0xFFFE hits, deliver 3 more hits -> hit_count=0xFFFF.
REQ-033 With AXIS_COLLISION_NAN_CHECK_EN, x=0x7FC00000, y=z=0, threshold 2.0 -> out_nan=1, out_hit=0, hit_count unchanged.
